// File: rtl/sound_pkg.sv
// Shared types and widths for the sound sample playback controller.
package sound_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        FETCH,
        CAPTURE,
        HOLD
    } sound_state_t;

    localparam int SOUND_DATA_W  = 16;
    localparam int SOUND_ADDR_W  = 14;
    localparam int SOUND_ATTEN_W = 4;

endpackage

// File: rtl/sound_playback_ctrl.sv
// Walks a single-port sample memory one word per sample_tick and hands each word
// downstream over valid/ready. Define SOUND_PLAYBACK_VOLUME_EN to add the atten shift.
module sound_playback_ctrl
    import sound_pkg::*;
#(
    parameter int SAMPLE_COUNT = 9000,
    parameter int ADDR_W       = SOUND_ADDR_W,
    parameter int DATA_W       = SOUND_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     play,
    input  logic                     stop,
    input  logic                     loop,
    input  logic                     sample_tick,
`ifdef SOUND_PLAYBACK_VOLUME_EN
    input  logic [SOUND_ATTEN_W-1:0] atten,
`endif
    output logic [ADDR_W-1:0]        rom_address,
    output logic                     rom_chipselect,
    output logic                     rom_clken,
    input  logic [DATA_W-1:0]        rom_readdata,
    output logic [DATA_W-1:0]        sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     underrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLE_COUNT - 1);

    sound_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              restart_q, restart_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic [DATA_W-1:0] cap_data;
    logic              tick_lost;

`ifdef SOUND_PLAYBACK_VOLUME_EN
    assign cap_data = $signed(rom_readdata) >>> atten;
`else
    assign cap_data = rom_readdata;
`endif

    // A tick only has somewhere to go in WAIT_TICK; anywhere else mid-playback it is lost.
    assign tick_lost = sample_tick &&
                       (state_q == FETCH || state_q == CAPTURE || state_q == HOLD);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        restart_d  = restart_q;
        data_d     = data_q;
        done_d     = 1'b0;
        underrun_d = underrun_q | tick_lost;

        case (state_q)
            IDLE: begin
                if (play && !stop) begin
                    state_d    = WAIT_TICK;
                    addr_d     = '0;
                    restart_d  = 1'b0;
                    underrun_d = 1'b0;
                end
            end
            WAIT_TICK: begin
                if (play) begin
                    addr_d    = '0;
                    restart_d = 1'b0;
                end
                if (sample_tick) state_d = FETCH;
            end
            FETCH: begin
                if (play) restart_d = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (play) restart_d = 1'b1;
                data_d  = cap_data;
                state_d = HOLD;
            end
            HOLD: begin
                if (sample_ready) begin
                    state_d = WAIT_TICK;
                    // A play landing on the acceptance cycle restarts just like a pending flag.
                    if (restart_q || play) begin
                        addr_d    = '0;
                        restart_d = 1'b0;
                    end else if (addr_q == LAST_ADDR) begin
                        if (loop) begin
                            addr_d = '0;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (play) begin
                    restart_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop && state_q != IDLE) begin
            state_d   = IDLE;
            restart_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            restart_q  <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            restart_q  <= restart_d;
            data_q     <= data_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign rom_address    = addr_q;
    assign rom_chipselect = (state_q == FETCH);
    assign rom_clken      = (state_q == FETCH);
    assign sample_data    = data_q;
    assign sample_valid   = (state_q == HOLD);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_sound_playback_ctrl.sv
// Directed bench for sound_playback_ctrl with a 4-word registered-address sample memory.
module tb_sound_playback_ctrl;
    import sound_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0, stop = 1'b0, loop = 1'b0, sample_tick = 1'b0;
    logic        sample_ready = 1'b0;
    logic [3:0]  atten = 4'd0;
    logic [13:0] rom_address;
    logic        rom_chipselect, rom_clken;
    logic [15:0] rom_readdata = 16'h0;
    logic [15:0] sample_data;
    logic        sample_valid, busy, done, underrun;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int tcnt = 0;
    bit tick_en = 1'b0;
    logic [15:0] acc_q[$];
    logic [13:0] fetch_q[$];
    logic [15:0] mem [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h8000};

    always #5 clk = ~clk;

    sound_playback_ctrl #(.SAMPLE_COUNT(4), .ADDR_W(14), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .stop(stop), .loop(loop),
        .sample_tick(sample_tick),
`ifdef SOUND_PLAYBACK_VOLUME_EN
        .atten(atten),
`endif
        .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_clken(rom_clken),
        .rom_readdata(rom_readdata), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .done(done), .underrun(underrun)
    );

    always @(posedge clk)
        if (rom_clken && rom_chipselect)
            rom_readdata <= (rom_address < 14'd4) ? mem[rom_address[1:0]] : 16'hDEAD;

    always @(negedge clk) begin
        if (sample_valid && sample_ready) acc_q.push_back(sample_data);
        if (done) done_cnt <= done_cnt + 1;
        if (rom_clken) fetch_q.push_back(rom_address);
    end

    task automatic clk1();
        sample_tick = sample_tick || (tick_en && tcnt == 0);
        tcnt = (tcnt == 9) ? 0 : tcnt + 1;
        @(posedge clk); #1;
        play = 1'b0; stop = 1'b0; sample_tick = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({sample_valid, busy, done, underrun, rom_chipselect, rom_clken} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 000000",
                {sample_valid, busy, done, underrun, rom_chipselect, rom_clken});
        end
        tests++;
        if (sample_data !== 16'h0 || rom_address !== 14'h0) begin
            fails++; $display("FAIL reset_data: data %h addr %h want 0", sample_data, rom_address);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        clk1();
    endtask

    task automatic test_basic();
        int base = acc_q.size();
        int fbase = fetch_q.size();
        int dbase = done_cnt;
        sample_ready = 1'b1; loop = 1'b0;
        play = 1'b1; clk1();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b want 1", busy); end
        clk1(); clk1();
        sample_tick = 1'b1; clk1();
        tests++;
        if (sample_valid !== 1'b0 || rom_clken !== 1'b1) begin
            fails++; $display("FAIL basic_fetch: valid %b clken %b want 0/1", sample_valid, rom_clken);
        end
        clk1();
        tests++;
        if (sample_valid !== 1'b0) begin fails++; $display("FAIL basic_lat2: valid %b want 0", sample_valid); end
        clk1();
        tests++;
        if (sample_valid !== 1'b1 || sample_data !== 16'h0001) begin
            fails++; $display("FAIL basic_lat3: valid %b data %h want 1/0001", sample_valid, sample_data);
        end
        clk1();
        tick_en = 1'b1; tcnt = 0;
        repeat (50) clk1();
        tick_en = 1'b0;
        tests++;
        if (acc_q.size() - base != 4) begin
            fails++; $display("FAIL basic_count: got %0d want 4", acc_q.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (acc_q[base+k] !== mem[k] || fetch_q[fbase+k] !== 14'(k)) begin
                    fails++; $display("FAIL basic_seq%0d: data %h addr %0d want %h/%0d",
                        k, acc_q[base+k], fetch_q[fbase+k], mem[k], k);
                end
            end
        end
        tests++;
        if (done_cnt - dbase != 1 || busy !== 1'b0 || underrun !== 1'b0) begin
            fails++; $display("FAIL basic_end: dones %0d busy %b underrun %b want 1/0/0",
                done_cnt - dbase, busy, underrun);
        end
    endtask

    task automatic test_backpressure();
        int base = acc_q.size();
        int dbase = done_cnt;
        logic [15:0] held;
        bit stable = 1'b1;
        sample_ready = 1'b1;
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        for (int i = 0; i < 60 && acc_q.size() - base < 1; i++) clk1();
        sample_ready = 1'b0;
        for (int i = 0; i < 60 && !sample_valid; i++) clk1();
        tests++;
        if (sample_valid !== 1'b1 || sample_data !== 16'h0002) begin
            fails++; $display("FAIL bp_second: valid %b data %h want 1/0002", sample_valid, sample_data);
        end
        held = sample_data;
        repeat (25) begin
            clk1();
            if (sample_valid !== 1'b1 || sample_data !== held) stable = 1'b0;
        end
        tests++;
        if (!stable) begin fails++; $display("FAIL bp_stable: data %h want %h held", sample_data, held); end
        tests++;
        if (underrun !== 1'b1) begin fails++; $display("FAIL bp_underrun: got %b want 1", underrun); end
        sample_ready = 1'b1;
        repeat (40) clk1();
        tick_en = 1'b0;
        tests++;
        if (acc_q.size() - base != 4 || acc_q[base+1] !== 16'h0002 || acc_q[base+2] !== 16'h0003
            || acc_q[base+3] !== 16'h8000 || done_cnt - dbase != 1) begin
            fails++; $display("FAIL bp_after: count %0d third %h dones %0d want 4/0003/1",
                acc_q.size() - base, acc_q[base+2], done_cnt - dbase);
        end
    endtask

    task automatic test_loop();
        int base = acc_q.size();
        int dbase = done_cnt;
        sample_ready = 1'b1; loop = 1'b1;
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        repeat (100) clk1();
        tests++;
        if (acc_q.size() - base < 9) begin
            fails++; $display("FAIL loop_count: got %0d want >=9", acc_q.size() - base);
        end else begin
            for (int k = 0; k < 9; k++) begin
                tests++;
                if (acc_q[base+k] !== mem[k%4]) begin
                    fails++; $display("FAIL loop_seq%0d: got %h want %h", k, acc_q[base+k], mem[k%4]);
                end
            end
        end
        sample_ready = 1'b0;
        for (int i = 0; i < 40 && !sample_valid; i++) clk1();
        stop = 1'b1; clk1();
        tests++;
        if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL loop_stop: valid %b busy %b want 0/0", sample_valid, busy);
        end
        repeat (3) clk1();
        tests++;
        if (done_cnt != dbase) begin fails++; $display("FAIL loop_nodone: dones %0d want 0", done_cnt - dbase); end
        tick_en = 1'b0; loop = 1'b0; sample_ready = 1'b1;
    endtask

    task automatic test_retrigger();
        int fbase;
        int dbase = done_cnt;
        bit found = 1'b0;
        sample_ready = 1'b1;
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (sample_valid && sample_data == 16'h0003) begin found = 1'b1; break; end
            clk1();
        end
        sample_ready = 1'b0;
        tests++;
        if (!found) begin fails++; $display("FAIL retrig_hold3: data %h want 0003", sample_data); end
        play = 1'b1; clk1();
        fbase = fetch_q.size();
        sample_ready = 1'b1; clk1();
        for (int i = 0; i < 40 && fetch_q.size() <= fbase; i++) clk1();
        tests++;
        if (fetch_q.size() <= fbase || fetch_q[fbase] !== 14'd0) begin
            fails++; $display("FAIL retrig_addr: fetches %0d addr %0d want addr 0",
                fetch_q.size() - fbase, (fetch_q.size() > fbase) ? fetch_q[fbase] : 14'h3fff);
        end
        for (int i = 0; i < 10 && !sample_valid; i++) clk1();
        tests++;
        if (sample_data !== 16'h0001) begin fails++; $display("FAIL retrig_data: got %h want 0001", sample_data); end
        stop = 1'b1; clk1();
        tick_en = 1'b0;
        tests++;
        if (done_cnt != dbase || busy !== 1'b0) begin
            fails++; $display("FAIL retrig_end: dones %0d busy %b want 0/0", done_cnt - dbase, busy);
        end
    endtask

    task automatic test_play_stop();
        int dbase = done_cnt;
        sample_ready = 1'b0;
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        for (int i = 0; i < 40 && !sample_valid; i++) clk1();
        play = 1'b1; stop = 1'b1; clk1();
        tests++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            fails++; $display("FAIL ps_busy: busy %b valid %b want 0/0", busy, sample_valid);
        end
        repeat (5) clk1();
        tests++;
        if (done_cnt != dbase || busy !== 1'b0) begin
            fails++; $display("FAIL ps_after: dones %0d busy %b want 0/0", done_cnt - dbase, busy);
        end
        play = 1'b1; stop = 1'b1; clk1();
        clk1();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL ps_idle: busy %b want 0", busy); end
        tick_en = 1'b0; sample_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int fbase;
        bit found = 1'b0;
        sample_ready = 1'b1;
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (sample_valid && sample_data == 16'h0003) begin found = 1'b1; break; end
            clk1();
        end
        sample_ready = 1'b0;
        tests++;
        if (!found || rom_address !== 14'd2) begin
            fails++; $display("FAIL rst_prep: data %h addr %0d want 0003/2", sample_data, rom_address);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({sample_valid, busy, done, underrun, rom_clken} !== 5'b0 || sample_data !== 16'h0
            || rom_address !== 14'h0) begin
            fails++; $display("FAIL rst_async: flags %b data %h addr %0d want 0",
                {sample_valid, busy, done, underrun, rom_clken}, sample_data, rom_address);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        sample_ready = 1'b1; tick_en = 1'b0;
        fbase = fetch_q.size();
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        for (int i = 0; i < 40 && !sample_valid; i++) clk1();
        tests++;
        if (fetch_q.size() <= fbase || fetch_q[fbase] !== 14'd0 || sample_data !== 16'h0001) begin
            fails++; $display("FAIL rst_restart: data %h want 0001 from addr 0", sample_data);
        end
        stop = 1'b1; clk1();
        tick_en = 1'b0;
    endtask

`ifdef SOUND_PLAYBACK_VOLUME_EN
    task automatic test_volume();
        int base = acc_q.size();
        logic [15:0] exp_v [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hE000};
        sample_ready = 1'b1; atten = 4'd2;
        play = 1'b1; clk1();
        tick_en = 1'b1; tcnt = 0;
        repeat (50) clk1();
        tick_en = 1'b0;
        tests++;
        if (acc_q.size() - base != 4) begin
            fails++; $display("FAIL vol_count: got %0d want 4", acc_q.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (acc_q[base+k] !== exp_v[k]) begin
                    fails++; $display("FAIL vol_seq%0d: got %h want %h", k, acc_q[base+k], exp_v[k]);
                end
            end
        end
        atten = 4'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_loop();
        test_retrigger();
        test_play_stop();
        test_reset_mid();
`ifdef SOUND_PLAYBACK_VOLUME_EN
        test_volume();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sound_playback_ctrl.md
Name: sound_playback_ctrl

Overview:
- Sequences one single-port 16-bit sound-sample memory, e.g. a tank crawl or shot effect.
- On a play request it walks the memory from word 0 to SAMPLE_COUNT-1, fetching one word per sample_tick.
- It presents each word to the audio output path through a valid/ready handshake.
- It sits between the game-logic command registers and the audio codec feeder.

Parameters:
- SAMPLE_COUNT, 9000, number of valid words in the attached sample memory.
- ADDR_W, 14, sample memory address width; must satisfy 2**ADDR_W >= SAMPLE_COUNT.
- DATA_W, 16, sample width; samples are signed two's complement.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- play  in  1  one-cycle pulse: start playback, or restart it.
- stop  in  1  one-cycle pulse: abort playback.
- loop  in  1  level; when 1, wrap to word 0 after the last word instead of finishing.
- sample_tick  in  1  one-cycle pulse at the audio sample rate.
- rom_address  out  ADDR_W  address to the sample memory.
- rom_chipselect  out  1  memory select.
- rom_clken  out  1  memory clock enable; the memory registers the address on this.
- rom_readdata  in  DATA_W  memory data; valid the cycle after an enabled address edge.
- sample_data  out  DATA_W  current sample.
- sample_valid  out  1  sample_data is valid.
- sample_ready  in  1  downstream accepts the sample.
- busy  out  1  playback in progress (state != IDLE).
- done  out  1  one-cycle pulse when a non-looping playback finishes.
- underrun  out  1  sticky; a tick arrived while the block was not in WAIT_TICK.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0; restart flag 0.
- States: IDLE, WAIT_TICK, FETCH, CAPTURE, HOLD.
- IDLE: play -> WAIT_TICK with addr=0; underrun cleared.
- WAIT_TICK: sample_tick -> FETCH.
- FETCH (1 cycle): rom_chipselect=1, rom_clken=1, rom_address=addr -> CAPTURE.
- CAPTURE (1 cycle): register rom_readdata into sample_data; sample_valid=1 from the next cycle -> HOLD.
  - Latency: sample_tick to sample_valid high = 3 cycles.
- HOLD: sample_valid=1 and sample_data stable until the cycle with sample_ready=1. On that cycle:
  - If the restart flag is set: addr=0, clear the flag -> WAIT_TICK.
  - Else if addr == SAMPLE_COUNT-1: if loop, addr=0 -> WAIT_TICK; otherwise done=1 for one cycle -> IDLE.
  - Else addr+1 -> WAIT_TICK.
- loop is sampled only at the wrap decision.
- rom_address always equals addr; rom_clken=0 outside FETCH, so the memory output holds.
- play while busy: sets the restart flag, which is applied at the next HOLD acceptance.
  - Restart during WAIT_TICK applies immediately: addr=0, state unchanged.
- stop in any non-IDLE state: the next cycle is IDLE, sample_valid=0, restart flag cleared, no done pulse.
  - This is the only case where valid drops without ready.
- play and stop in the same cycle: stop wins.
- sample_tick in FETCH, CAPTURE or HOLD: the tick is dropped and underrun is set. underrun clears only on an accepted play from IDLE.
- sample_tick and sample_ready in the same HOLD cycle: the tick is dropped and underrun is set.
- addr arithmetic: unsigned ADDR_W bits; never exceeds SAMPLE_COUNT-1.
- Async reset mid-playback: everything returns to reset values immediately.

Optional Feature:
- Macro SOUND_PLAYBACK_VOLUME_EN.
- Defined:
  - Adds input port atten (4 bits).
  - In CAPTURE, sample_data = $signed(rom_readdata) >>> atten (arithmetic shift; atten=0 passes data through).
  - atten is sampled in the CAPTURE cycle only.
- Undefined: no atten port; sample_data = rom_readdata unchanged.

Decomposition:
- Shared package sound_pkg holds:
  - state enum sound_state_t {IDLE, WAIT_TICK, FETCH, CAPTURE, HOLD};
  - localparams SOUND_DATA_W=16, SOUND_ADDR_W=14;
  - the atten width constant.
- No sub-module: the FSM and address counter stay in one module. The bench models the memory as a 1-cycle registered-address array.

Test Plan:
- Basic playback: SAMPLE_COUNT=4, memory {0x0001,0x0002,0x0003,0x8000}, loop=0, ready tied 1, tick every 10 cycles, one play -> samples 0x0001,0x0002,0x0003,0x8000 in order; each valid 3 cycles after its tick; done pulses once; busy falls.
- Backpressure: hold ready=0 for 25 cycles on sample 2 with a tick every 10 -> sample 2 held stable; underrun=1; sample 3 follows after acceptance.
- Loop: loop=1 for 10 ticks -> sequence 1,2,3,0x8000,1,2,...; no done pulse; stop -> IDLE next cycle, valid=0.
- Retrigger: play during sample 3's HOLD -> after acceptance, next fetched address is 0.
- Same-cycle play+stop while busy -> IDLE, no done. play+stop from IDLE -> remains IDLE.
- With SOUND_PLAYBACK_VOLUME_EN: atten=2 on word 0x8000 -> sample_data 0xE000. Word 0x0003 -> 0x0000.
- Reset: assert reset_n=0 during HOLD -> all outputs 0 asynchronously; play after release restarts at address 0.
